// File: rtl/subtractor_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width: wide enough to hold WIDTH/STEP itself.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned step);
    int unsigned w;
    w = $clog2(width / step);
    return w + 1;
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational STEP-bit ripple-borrow subtractor slice.
module sub_slice #(
  parameter int unsigned STEP = 1
) (
  input  logic [STEP-1:0] x,
  input  logic [STEP-1:0] y,
  input  logic            bi,
  output logic [STEP-1:0] d,
  output logic            bo
);

  // Ripple the borrow from LSB to MSB through the slice.
  always_comb begin
    logic w_b;
    d   = '0;
    w_b = bi;
    for (int i = 0; i < int'(STEP); i++) begin
      d[i] = x[i] ^ y[i] ^ w_b;
      w_b  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b);
    end
    bo = w_b;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: out = a - b, STEP bits per clock, LSB first.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow
);

  localparam int unsigned STEPS = WIDTH / STEP;
  localparam int unsigned CW    = cnt_width(WIDTH, STEP);

  // STEP must evenly divide the operand width.
  generate
    if (STEP == 0 || (WIDTH % STEP) != 0) begin : g_bad_step
      $error("serial_subtractor: STEP must divide WIDTH");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_res_next;
  logic [CW-1:0]    r_cnt;
  logic             r_bi;
  logic             r_borrow;
  logic [STEP-1:0]  w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(STEPS - 1));

  sub_slice #(.STEP(STEP)) u_slice (
    .x  (r_a[STEP-1:0]),
    .y  (r_b[STEP-1:0]),
    .bi (r_bi),
    .d  (w_d),
    .bo (w_bo)
  );

  // New difference bits enter the result register at the MSB end.
  assign w_res_next = (r_res >> STEP) | (WIDTH'(w_d) << (WIDTH - STEP));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, per-step shifting and borrow chaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_bi  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_cnt <= '0;
      r_bi  <= 1'b0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> STEP;
      r_b   <= r_b >> STEP;
      r_res <= w_res_next;
      r_cnt <= r_cnt + CW'(1);
      r_bi  <= w_bo;
    end
  end

  // Result registers update only on the final step and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= '0;
      r_borrow <= 1'b0;
    end else if (w_last) begin
      r_out    <= w_res_next;
      r_borrow <= w_bo;
    end
  end

  assign ready  = (r_state == IDLE);
  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign out    = r_out;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at STEP = 1, 4 and 16.
module tb_serial_subtractor;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  start_v;
  logic [2:0]  ready_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  borrow_v;
  logic [15:0] out_v [3];

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(16), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .out(out_v[0]), .borrow(borrow_v[0])
  );

  serial_subtractor #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .out(out_v[1]), .borrow(borrow_v[1])
  );

  serial_subtractor #(.WIDTH(16), .STEP(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .out(out_v[2]), .borrow(borrow_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One operation on instance sel; optionally pokes start/a/b mid-RUN.
  task automatic run_op(input int sel, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [15:0] eo, input logic eb, input int elat,
                        input bit inject, input string name);
    int          guard;
    int          lat;
    logic [15:0] prev;
    guard = 0;
    while (ready_v[sel] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (ready_v[sel] !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_before_start: got %b want 1", name, ready_v[sel]);
    end
    @(negedge clk);
    a = ta;
    b = tbv;
    start_v[sel] = 1'b1;
    prev = out_v[sel];
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    n_cmp++;
    if (elat > 1 && busy_v[sel] !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_accept: got %b want 1", name, busy_v[sel]);
    end
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_v[sel] === 1'b1) begin
        lat = k;
        break;
      end
      n_cmp++;
      if (out_v[sel] !== prev) begin
        n_err++;
        $display("FAIL %s out_hold_k%0d: got %0d want %0d", name, k, out_v[sel], prev);
      end
      if (inject && k == 5) begin
        a = 16'd100;
        b = 16'd1;
        start_v[sel] = 1'b1;
      end
      if (inject && k == 6) start_v[sel] = 1'b0;
    end
    n_cmp++;
    if (lat != elat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
    end
    n_cmp++;
    if (out_v[sel] !== eo) begin
      n_err++;
      $display("FAIL %s out: got %0d want %0d", name, out_v[sel], eo);
    end
    n_cmp++;
    if (borrow_v[sel] !== eb) begin
      n_err++;
      $display("FAIL %s borrow: got %b want %b", name, borrow_v[sel], eb);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done_v[sel] !== 1'b0 || ready_v[sel] !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_pulse_end: got done=%b ready=%b want done=0 ready=1",
               name, done_v[sel], ready_v[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_v = '0;
    a = '0;
    b = '0;
    #2 rst = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (out_v[s] !== 16'd0 || borrow_v[s] !== 1'b0 || done_v[s] !== 1'b0 ||
          ready_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got out=%0d borrow=%b done=%b ready=%b busy=%b want 0 0 0 1 0",
                 s, out_v[s], borrow_v[s], done_v[s], ready_v[s], busy_v[s]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_underflow();
    run_op(0, 16'd0, 16'd1, 16'd65535, 1'b1, 16, 1'b0, "underflow_0m1");
  endtask

  task automatic test_normal();
    run_op(0, 16'd23, 16'd5, 16'd18, 1'b0, 16, 1'b0, "normal_23m5");
    run_op(0, 16'd5, 16'd23, 16'd65518, 1'b1, 16, 1'b0, "normal_5m23");
  endtask

  task automatic test_boundary();
    run_op(0, 16'd65535, 16'd65535, 16'd0, 1'b0, 16, 1'b0, "bound_max_max");
    run_op(0, 16'd32768, 16'd65535, 16'd32769, 1'b1, 16, 1'b0, "bound_msb_max");
  endtask

  task automatic test_start_while_busy();
    int extra;
    run_op(0, 16'd23, 16'd5, 16'd18, 1'b0, 16, 1'b1, "busy_start_23m5");
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_v[0] === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL busy_start_extra_done: got %0d want 0", extra);
    end
    n_cmp++;
    if (out_v[0] !== 16'd18) begin
      n_err++;
      $display("FAIL busy_start_out_after: got %0d want 18", out_v[0]);
    end
  endtask

  // Abort an operation with reset after 'steps' edges, then rerun 10 - 3.
  task automatic test_reset_mid(input int sel, input int steps, input int lat, input string name);
    int got_done;
    @(negedge clk);
    a = 16'd1234;
    b = 16'd1;
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    repeat (steps) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ready_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || done_v[sel] !== 1'b0 ||
        out_v[sel] !== 16'd0 || borrow_v[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL %s reset_mid_state: got ready=%b busy=%b done=%b out=%0d borrow=%b want 1 0 0 0 0",
               name, ready_v[sel], busy_v[sel], done_v[sel], out_v[sel], borrow_v[sel]);
    end
    @(negedge clk);
    rst = 1'b0;
    got_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_v[sel] === 1'b1) got_done++;
    end
    n_cmp++;
    if (got_done != 0) begin
      n_err++;
      $display("FAIL %s reset_mid_no_done: got %0d want 0", name, got_done);
    end
    run_op(sel, 16'd10, 16'd3, 16'd7, 1'b0, lat, 1'b0, name);
  endtask

  task automatic test_step_variants();
    test_reset_mid(1, 2, 4, "step4_reset_10m3");
    run_op(1, 16'd5, 16'd23, 16'd65518, 1'b1, 4, 1'b0, "step4_5m23");
    run_op(2, 16'd10, 16'd3, 16'd7, 1'b0, 1, 1'b0, "step16_10m3");
    run_op(2, 16'd32768, 16'd65535, 16'd32769, 1'b1, 1, 1'b0, "step16_msb_max");
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_normal();
    test_boundary();
    test_start_while_busy();
    test_reset_mid(0, 7, 16, "step1_reset_10m3");
    test_step_variants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
